// File: rtl/vx_icache_req_arb.sv
// Round-robin merge of NUM_REQS icache request channels into one stream through a small
// elastic FIFO; the winner's index is appended to the tag for response demultiplexing.
module vx_icache_req_arb #(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned ADDR_WIDTH   = 30,
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned BUF_DEPTH    = 2,
    parameter int unsigned LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr_in,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag_in,
    output logic [NUM_REQS-1:0]               req_ready_in,
    output logic                              req_valid_out,
    output logic [ADDR_WIDTH-1:0]             req_addr_out,
    output logic [TAG_WIDTH+LOG_NUM_REQS-1:0] req_tag_out,
    input  logic                              req_ready_out,
    output logic [31:0]                       stall_cnt
);

    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned OUT_TAG_W = TAG_WIDTH + LOG_NUM_REQS;

    logic [LOG_NUM_REQS-1:0] rr_ptr_q, rr_ptr_d, grant_idx;
    logic [NUM_REQS-1:0]     valid_rot;
    logic                    grant_found, push, pop;
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [TAG_WIDTH-1:0]    sel_tag;
    logic [ADDR_WIDTH-1:0]   addr_mem [BUF_DEPTH];
    logic [OUT_TAG_W-1:0]    tag_mem  [BUF_DEPTH];

    // Rotate valids so that bit 0 is the channel at rr_ptr, then take the first set bit.
    always_comb begin
        valid_rot   = NUM_REQS'({req_valid_in, req_valid_in} >> rr_ptr_q);
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            if (!grant_found && valid_rot[k]) begin
                grant_found = 1'b1;
                grant_idx   = LOG_NUM_REQS'((32'(rr_ptr_q) + k) % NUM_REQS);
            end
        end
    end

    // Full blocks the grant even when a pop is pending, keeping ready free of req_ready_out.
    assign push          = grant_found && (count_q < CNT_W'(BUF_DEPTH)) && !reset;
    assign pop           = req_valid_out && req_ready_out;
    assign req_ready_in  = push ? (NUM_REQS'(1) << grant_idx) : '0;
    assign req_valid_out = (count_q != '0);
    assign req_addr_out  = addr_mem[rd_ptr_q];
    assign req_tag_out   = tag_mem[rd_ptr_q];

    always_comb begin
        sel_addr = '0;
        sel_tag  = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            if (grant_idx == LOG_NUM_REQS'(k)) begin
                sel_addr = req_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_tag  = req_tag_in[k*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (32'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + LOG_NUM_REQS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= sel_addr;
            tag_mem[wr_ptr_q]  <= {sel_tag, grant_idx};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            stall_cnt <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (req_valid_out && !req_ready_out && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_vx_icache_req_arb.sv
// Table-driven bench for vx_icache_req_arb with a scoreboard of expected output entries;
// includes a NUM_REQS=1 instance for the degenerate case.
module tb_vx_icache_req_arb;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int TW = 8;
    localparam int LW = 2;
    localparam int NV = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]      req_valid_in, req_ready_in;
    logic [N*AW-1:0]   req_addr_in;
    logic [N*TW-1:0]   req_tag_in;
    logic              req_valid_out, req_ready_out;
    logic [AW-1:0]     req_addr_out;
    logic [TW+LW-1:0]  req_tag_out;
    logic [31:0]       stall_cnt;

    logic [AW-1:0] ch_addr [N];
    logic [TW-1:0] ch_tag  [N];
    int            seq     [N];

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_addr_in[i*AW +: AW] = ch_addr[i];
        assign req_tag_in[i*TW +: TW]  = ch_tag[i];
    end

    vx_icache_req_arb dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_in  (req_valid_in),
        .req_addr_in   (req_addr_in),
        .req_tag_in    (req_tag_in),
        .req_ready_in  (req_ready_in),
        .req_valid_out (req_valid_out),
        .req_addr_out  (req_addr_out),
        .req_tag_out   (req_tag_out),
        .req_ready_out (req_ready_out),
        .stall_cnt     (stall_cnt)
    );

    logic          s_valid, s_ready, s_vout, s_rdy_out;
    logic [AW-1:0] s_addr, s_aout;
    logic [TW-1:0] s_tag;
    logic [TW:0]   s_tout;
    logic [31:0]   s_stall;

    vx_icache_req_arb #(.NUM_REQS(1)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .req_valid_in  (s_valid),
        .req_addr_in   (s_addr),
        .req_tag_in    (s_tag),
        .req_ready_in  (s_ready),
        .req_valid_out (s_vout),
        .req_addr_out  (s_aout),
        .req_tag_out   (s_tout),
        .req_ready_out (s_rdy_out),
        .stall_cnt     (s_stall)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic         rdy;
        logic [N-1:0] exp_rdy;
        logic         exp_vout;
        logic         chk_stall;
        int unsigned  exp_stall;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [TW+LW-1:0] tag;
    } sb_t;

    vec_t vecs [NV];
    sb_t  sb [$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh(input int g);
        seq[g]++;
        ch_addr[g] = AW'(32'h100 * (g + 1) + seq[g]);
        ch_tag[g]  = TW'(g * 16 + seq[g]);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = 0;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic run_vec(input int i);
        int  g;
        sb_t e;
        g = onehot_idx(vecs[i].exp_rdy);
        req_valid_in  = vecs[i].valid;
        req_ready_out = vecs[i].rdy;
        @(negedge clk);
        check($sformatf("ready_in v%0d", i), 64'(req_ready_in), 64'(vecs[i].exp_rdy));
        check($sformatf("valid_out v%0d", i), 64'(req_valid_out), 64'(vecs[i].exp_vout));
        if (vecs[i].chk_stall)
            check($sformatf("stall_cnt v%0d", i), 64'(stall_cnt), 64'(vecs[i].exp_stall));
        if (vecs[i].exp_vout && vecs[i].rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard v%0d: got pop expected empty queue", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("addr_out v%0d", i), 64'(req_addr_out), 64'(e.addr));
                check($sformatf("tag_out v%0d", i), 64'(req_tag_out), 64'(e.tag));
            end
        end
        if (vecs[i].exp_rdy != '0) sb.push_back('{ch_addr[g], {ch_tag[g], LW'(g)}});
        @(posedge clk);
        #1;
        if (vecs[i].exp_rdy != '0) refresh(g);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // valid, rdy_out, expected ready_in, expected valid_out, check stall, expected stall
        vecs[0]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 1'b1, 0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 0};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 0};
        vecs[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0, 0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 0};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1, 0};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 1};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2};
        vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 3};
        vecs[10] = '{4'b1111, 1'b0, 4'b0100, 1'b1, 1'b1, 3};
        vecs[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 4};
        // after reset: fill, stall count, drain in order, push/pop at count 1
        vecs[12] = '{4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1, 0};
        vecs[13] = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1, 0};
        vecs[14] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 1};
        vecs[15] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2};
        vecs[16] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 3};
        vecs[17] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 3};
        vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 3};
        vecs[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 3};

        for (int g = 0; g < N; g++) begin
            seq[g] = 0;
            refresh(g);
        end
        s_valid = 1'b0; s_addr = '0; s_tag = '0; s_rdy_out = 1'b1;
        req_ready_out = 1'b0;
        req_valid_in  = 4'b1111;
        reset = 1'b1;
        #2;
        check("reset valid_out", 64'(req_valid_out), 64'd0);
        check("reset ready_in", 64'(req_ready_in), 64'd0);
        check("reset stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid_in = 4'b0000;

        // Single request on channel 2
        ch_addr[2] = AW'(32'h1000);
        ch_tag[2]  = 8'h5A;
        req_valid_in  = 4'b0100;
        req_ready_out = 1'b1;
        @(negedge clk);
        check("single ready_in", 64'(req_ready_in), 64'b0100);
        check("single valid_out c0", 64'(req_valid_out), 64'd0);
        @(posedge clk); #1;
        req_valid_in = 4'b0000;
        refresh(2);
        @(negedge clk);
        check("single valid_out c1", 64'(req_valid_out), 64'd1);
        check("single addr_out", 64'(req_addr_out), 64'h1000);
        check("single tag_out", 64'(req_tag_out), 64'h16A);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(i);

        // Asynchronous reset with count=2 and rr_ptr=3
        #2;
        reset = 1'b1;
        #1;
        check("midreset valid_out", 64'(req_valid_out), 64'd0);
        check("midreset ready_in", 64'(req_ready_in), 64'd0);
        check("midreset stall_cnt", 64'(stall_cnt), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 12; i < NV; i++) run_vec(i);
        check("scoreboard empty", 64'(sb.size()), 64'd0);

        // NUM_REQS=1: back-to-back at one per cycle, index bit always 0
        s_valid = 1'b1;
        s_addr  = AW'(32'h2000);
        s_tag   = 8'hA0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("n1 ready c%0d", k), 64'(s_ready), (k < 4) ? 64'd1 : 64'd0);
            if (k == 0) begin
                check("n1 valid_out c0", 64'(s_vout), 64'd0);
            end else begin
                check($sformatf("n1 valid_out c%0d", k), 64'(s_vout), 64'd1);
                check($sformatf("n1 addr c%0d", k), 64'(s_aout), 64'(32'h2000 + k - 1));
                check($sformatf("n1 tag c%0d", k), 64'(s_tout), 64'({8'(8'hA0 + k - 1), 1'b0}));
                check($sformatf("n1 tag lsb c%0d", k), 64'(s_tout[0]), 64'd0);
            end
            @(posedge clk); #1;
            if (k < 3) begin
                s_addr = AW'(32'h2000 + k + 1);
                s_tag  = 8'(8'hA0 + k + 1);
            end else begin
                s_valid = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vx_icache_req_arb.md
Name: vx_icache_req_arb

Overview:
- Parametrised successor to the single-channel icache request interface.
- Merges NUM_REQS independent icache request channels into one request stream to the icache. Uses round-robin arbitration and a BUF_DEPTH-entry elastic output buffer.
- Appends the winning requester index to the tag so the response path can demultiplex.
- Sits between the per-warp/per-core fetch units and the icache core request port.

Parameters:
- NUM_REQS, 4, number of requesting channels (>=1).
- ADDR_WIDTH, 30, word address width.
- TAG_WIDTH, 8, per-channel tag width.
- BUF_DEPTH, 2, output buffer entries (power of 2, >=2).
- LOG_NUM_REQS, max(1, clog2(NUM_REQS)), derived; index field width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid_in  in  NUM_REQS  per-channel request valid.
- req_addr_in  in  NUM_REQS*ADDR_WIDTH  per-channel word address; channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_tag_in  in  NUM_REQS*TAG_WIDTH  per-channel tag; packed the same way.
- req_ready_in  out  NUM_REQS  per-channel accept (one-hot or zero).
- req_valid_out  out  1  merged request valid.
- req_addr_out  out  ADDR_WIDTH  merged address.
- req_tag_out  out  TAG_WIDTH+LOG_NUM_REQS  {channel tag, requester index}; index in the LSBs.
- req_ready_out  in  1  icache accepts the merged request.
- stall_cnt  out  32  cycles with req_valid_out=1 and req_ready_out=0; saturates at 2^32-1.

Behaviour:
Reset (asynchronous, immediate):
- Buffer count, read pointer and write pointer = 0.
- Round-robin pointer = 0.
- stall_cnt = 0.
- req_valid_out = 0; req_ready_in = 0.
- req_addr_out and req_tag_out are don't-care while req_valid_out = 0.

Handshake:
- Transfer on a channel or the output occurs when valid & ready are high at a rising clk.
- A valid request is held stable until accepted.

Arbitration:
- Combinational search over req_valid_in, starting at rr_ptr and wrapping modulo NUM_REQS. The first valid channel wins.
- Grant only when count < BUF_DEPTH.
- req_ready_in = one-hot of the winner when granting, else 0.
- The ready path is independent of req_ready_out; no combinational path from req_ready_out to req_ready_in.
- On accept of channel g: rr_ptr <= (g+1) mod NUM_REQS.
- With no accept, rr_ptr holds.

Buffer:
- Circular FIFO of {addr, tag, index}.
- Push on accept; pop when req_valid_out & req_ready_out.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count == BUF_DEPTH): no grant, even if a pop occurs in the same cycle.
- Pointers wrap at BUF_DEPTH.
- req_valid_out = (count != 0). The outputs present the head entry.

Latency and throughput:
- An accepted request appears at the output at the earliest on the next cycle (1-cycle latency).
- Sustained throughput is 1 request/cycle when req_ready_out stays high.

Index and tag:
- The index field is the winner's number, zero-extended to LOG_NUM_REQS.
- NUM_REQS=1: the index bit is 0 and arbitration is degenerate.

stall_cnt:
- Increments each cycle where req_valid_out & !req_ready_out.
- Holds at all-ones (saturates).

Test Plan:
- Reset mid-operation: assert reset with count=2 and rr_ptr=3 → req_valid_out, req_ready_in and stall_cnt go to 0 asynchronously. After release, the first request from channel 0 is granted before channel 3.
- Single channel: ch2 valid, addr 0x1000, tag 0x5A, req_ready_out=1 → req_ready_in=4'b0100 in cycle 0. Next cycle: req_valid_out=1, addr_out 0x1000, tag_out {0x5A, 2'd2}.
- Round robin: all 4 channels valid continuously, req_ready_out=1 → grant order 0,1,2,3,0,… with one grant per cycle and no channel starved.
- Backpressure/full: all valid, req_ready_out=0 → exactly 2 grants (ch0, ch1), then req_ready_in=0. stall_cnt counts 1,2,3… from the first output-valid cycle. Raising req_ready_out drains in order ch0, ch1, then ch2 is granted.
- Simultaneous push/pop at count=1: ch1 accepted while head pops → count stays 1, output order preserved.
- NUM_REQS=1 build: tag_out LSB always 0. Back-to-back requests pass at 1/cycle with 1-cycle latency.
